seg7_mux_driver: RTL and testbench
==================================

// Module: seg7_mux_driver
// PURPOSE
//  Sequential display stage fed directly by the bcd converter's 8-bit output.
//  Latches a two-digit packed BCD word {tens[7:4], ones[3:0]} on a load strobe.
//  Time-multiplexes the two digits onto one shared 7-segment bus with per-digit anodes.
//  Leading-zero blanking on the tens digit; dash shown for non-BCD nibbles.
// PARAMETERS
//  REFRESH_DIV  50000  clk cycles each digit stays selected; legal range >= 1
//  BLANK_LZ     1      1: tens anode held inactive while tens nibble == 0
// PORTS
//  clk     in   1  system clock; every register updates on its rising edge
//  rst     in   1  asynchronous, active-high reset
//  bcd_i   in   8  packed BCD {tens, ones}, taken from the bcd converter output w
//  load_i  in   1  1 at a rising edge: bcd_i is captured into data_q
//  seg_o   out  7  segments {g,f,e,d,c,b,a}, active-low (0 = segment lit)
//  an_o    out  2  digit anodes, active-low; an_o[0] = ones, an_o[1] = tens
// BEHAVIOUR
//  Registers:
//   - data_q[7:0]
//   - div_q: counts 0..REFRESH_DIV-1
//   - sel_q: 0 = ones, 1 = tens
//   - seg_o and an_o are registered outputs
//  Reset (async, takes effect immediately, no clock edge needed):
//   - data_q = 8'h00, div_q = 0, sel_q = 0
//   - an_o = 2'b11, seg_o = 7'h7F (all dark)
//  Divider:
//   - div_q increments every edge.
//   - At div_q == REFRESH_DIV-1 it wraps to 0 and sel_q toggles.
//   - With REFRESH_DIV = 1, sel_q toggles on every edge.
//  Load: data_q <= bcd_i at any edge where load_i = 1. Independent of the divider.
//  Output stage, every edge:
//   - seg_o/an_o are computed from the pre-edge sel_q and data_q.
//   - Latency is one edge from a sel_q or data_q change to the pins.
//   - load_i to lit segments: 2 edges, provided the loaded digit is currently selected.
//  Segment map (active-low):
//   - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10
//   - nibble A-F -> 3F (dash, only g lit)
//  Anodes:
//   - sel=0: an_o = 2'b10
//   - sel=1: an_o = 2'b01, except when BLANK_LZ = 1 and tens == 0: an_o = 2'b11, seg_o = 7'h7F
//  Simultaneous load and divider wrap at the same edge:
//   - Both take effect.
//   - The next output update shows the new data on the new digit.
//  Ones digit: never blanked; value 0 shows "0".
//  Reset mid-frame: the display goes dark immediately.
//   - First edge after release: an_o = 2'b10, seg_o = 7'h40.
//  Never drive both anodes active simultaneously.
// TESTING (bench uses REFRESH_DIV = 4, BLANK_LZ = 1)
//  1. Assert rst -> an_o = 11, seg_o = 7F. Release rst; 1 edge later -> an_o = 10, seg_o = 40.
//     Tens slot (edges 5-8) -> an_o = 11 (zero blanked).
//  2. One-cycle load_i with bcd_i = 8'h37.
//     -> ones slot: an_o = 10, seg_o = 78.
//     -> tens slot: an_o = 01, seg_o = 30.
//     Each slot lasts exactly 4 edges.
//  3. Load 8'h05 -> ones: seg_o = 12 (an_o = 10); tens slot: an_o = 11, seg_o = 7F.
//  4. Load 8'hA9 -> ones: seg_o = 10; tens: an_o = 01, seg_o = 3F (dash).
//  5. Load 8'h42 on the edge where div_q wraps to tens -> next edge: an_o = 01, seg_o = 19 (no stale 3).
//  6. Async rst pulse between edges while tens "3" is shown -> pins go to 11/7F with no clk edge.
//     After release: ones "0", data_q = 00.

Source files
------------

// File: rtl/seg7_mux_driver.sv
// Two-digit multiplexed 7-segment driver. It latches a packed BCD byte on a load strobe
// and alternates the ones and tens digits on a shared active-low segment bus.
module seg7_mux_driver #(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter bit          BLANK_LZ    = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] bcd_i,
    input  logic       load_i,
    output logic [6:0] seg_o,
    output logic [1:0] an_o
);

    localparam int unsigned DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

    typedef enum logic {
        SEL_ONES = 1'b0,
        SEL_TENS = 1'b1
    } sel_t;

    logic [7:0]       r_data;
    logic [DIV_W-1:0] r_div;
    sel_t             r_sel;

    logic [3:0] w_digit;
    logic [6:0] w_glyph;
    logic       w_blank;
    logic [6:0] w_seg;
    logic [1:0] w_an;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div <= '0;
            r_sel <= SEL_ONES;
        end else if (r_div == DIV_LAST) begin
            r_div <= '0;
            r_sel <= (r_sel == SEL_ONES) ? SEL_TENS : SEL_ONES;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
        end else if (load_i) begin
            r_data <= bcd_i;
        end
    end

    always_comb begin
        w_digit = (r_sel == SEL_TENS) ? r_data[7:4] : r_data[3:0];
        case (w_digit)
            4'd0:    w_glyph = 7'h40;
            4'd1:    w_glyph = 7'h79;
            4'd2:    w_glyph = 7'h24;
            4'd3:    w_glyph = 7'h30;
            4'd4:    w_glyph = 7'h19;
            4'd5:    w_glyph = 7'h12;
            4'd6:    w_glyph = 7'h02;
            4'd7:    w_glyph = 7'h78;
            4'd8:    w_glyph = 7'h00;
            4'd9:    w_glyph = 7'h10;
            default: w_glyph = 7'h3F;
        endcase
    end

    // Only the tens digit may be blanked; the ones digit always shows.
    always_comb begin
        w_blank = BLANK_LZ && (r_sel == SEL_TENS) && (r_data[7:4] == 4'd0);
        w_seg   = w_glyph;
        w_an    = (r_sel == SEL_TENS) ? 2'b01 : 2'b10;
        if (w_blank) begin
            w_seg = '1;
            w_an  = '1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_o <= '1;
            an_o  <= '1;
        end else begin
            seg_o <= w_seg;
            an_o  <= w_an;
        end
    end

endmodule

// File: tb/tb_seg7_mux_driver.sv
// Bench for seg7_mux_driver with a 4-edge refresh slot and leading-zero blanking.
// Per-edge expected pins come from a vector table and pass through a scoreboard queue.
module tb_seg7_mux_driver;

    logic       clk;
    logic       rst;
    logic [7:0] bcd_i;
    logic       load_i;
    logic [6:0] seg_o;
    logic [1:0] an_o;

    seg7_mux_driver #(
        .REFRESH_DIV(4),
        .BLANK_LZ   (1'b1)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bcd_i (bcd_i),
        .load_i(load_i),
        .seg_o (seg_o),
        .an_o  (an_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] bcd;
        logic [6:0] ones_seg;
        logic [1:0] tens_an;
        logic [6:0] tens_seg;
    } vec_t;

    vec_t vecs[8];

    int checks = 0;
    int errors = 0;

    logic [8:0] sb_q[$];

    int unsigned m_div;
    logic        m_sel;
    int          m_idx;

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got an=%b seg=%h, expected an=%b seg=%h",
                     name, act[8:7], act[6:0], exp[8:7], exp[6:0]);
        end
    endtask

    task automatic model_reset();
        m_div = 0;
        m_sel = 1'b0;
        m_idx = 0;
    endtask

    // One clock edge: push the expected pins, then compare one time unit after the edge.
    task automatic step(input logic ld, input int idx, input string name);
        logic [8:0] exp;
        logic [8:0] got;
        exp = m_sel ? {vecs[m_idx].tens_an, vecs[m_idx].tens_seg}
                    : {2'b10, vecs[m_idx].ones_seg};
        sb_q.push_back(exp);
        load_i = ld;
        bcd_i  = ld ? vecs[idx].bcd : 8'hEE;
        @(posedge clk);
        #1;
        load_i = 1'b0;
        if (m_div == 3) begin
            m_div = 0;
            m_sel = ~m_sel;
        end else begin
            m_div++;
        end
        if (ld) m_idx = idx;
        got = {an_o, seg_o};
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            chk(name, got, sb_q.pop_front());
        end
    endtask

    initial begin
        vecs[0] = '{8'h00, 7'h40, 2'b11, 7'h7F};
        vecs[1] = '{8'h37, 7'h78, 2'b01, 7'h30};
        vecs[2] = '{8'h05, 7'h12, 2'b11, 7'h7F};
        vecs[3] = '{8'hA9, 7'h10, 2'b01, 7'h3F};
        vecs[4] = '{8'h42, 7'h24, 2'b01, 7'h19};
        vecs[5] = '{8'h9F, 7'h3F, 2'b01, 7'h10};
        vecs[6] = '{8'h68, 7'h00, 2'b01, 7'h02};
        vecs[7] = '{8'h10, 7'h40, 2'b01, 7'h79};

        rst    = 1'b1;
        load_i = 1'b0;
        bcd_i  = 8'h00;
        #7;
        chk("reset_dark", {an_o, seg_o}, {2'b11, 7'h7F});
        @(posedge clk);
        #1;
        chk("reset_hold", {an_o, seg_o}, {2'b11, 7'h7F});
        #2 rst = 1'b0;
        #1;
        chk("release_no_edge", {an_o, seg_o}, {2'b11, 7'h7F});

        // Edges 1-4 show ones "0", edges 5-8 blank the zero tens digit.
        model_reset();
        for (int i = 0; i < 8; i++) step(1'b0, 0, "post_reset_frame");

        for (int v = 1; v < 8; v++) begin
            step(1'b1, v, "vec_load");
            for (int i = 0; i < 9; i++) step(1'b0, 0, "vec_frame");
        end

        // Load coinciding with the wrap into the tens slot.
        step(1'b1, 1, "wrap_pre_load");
        while (!(m_sel == 1'b0 && m_div == 3)) step(1'b0, 0, "wrap_align");
        step(1'b1, 4, "wrap_load");
        step(1'b0, 0, "wrap_tens_new");
        chk("wrap_no_stale", {an_o, seg_o}, {2'b01, 7'h19});
        for (int i = 0; i < 4; i++) step(1'b0, 0, "wrap_after");

        // Async reset pulse between edges while tens "3" is lit.
        step(1'b1, 1, "async_load");
        while (m_sel != 1'b1) step(1'b0, 0, "async_align");
        step(1'b0, 0, "async_tens_a");
        step(1'b0, 0, "async_tens_b");
        chk("async_tens_shown", {an_o, seg_o}, {2'b01, 7'h30});
        #2 rst = 1'b1;
        #1;
        chk("async_dark", {an_o, seg_o}, {2'b11, 7'h7F});
        #2 rst = 1'b0;
        #1;
        chk("async_dark_released", {an_o, seg_o}, {2'b11, 7'h7F});
        model_reset();
        step(1'b0, 0, "async_first_edge");
        chk("async_ones_zero", {an_o, seg_o}, {2'b10, 7'h40});
        for (int i = 0; i < 7; i++) step(1'b0, 0, "async_data_cleared");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
